// File: rtl/snowman_sprite_gen_if.sv
// rtl/snowman_sprite_gen_if.sv - raster-in / pixel-out bundle for snowman_sprite_gen
//
// Purpose: groups the raster timing inputs and the pixel/frame outputs of the
//          snowman sprite generator.
// Signals:
//   h_cnt[9:0]       horizontal raster counter, 0..799
//   v_cnt[9:0]       vertical raster counter, 0..524
//   visible          active-video flag aligned with h_cnt/v_cnt
//   vsync            active-low vertical sync
//   pause            freezes the animation while high
//   image_data[11:0] RGB444 {r,g,b}, registered
//   frame_cnt[7:0]   frames since reset, wraps
// Modports: master = raster source / pixel sink, slave = generator.

interface snowman_sprite_gen_if;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic        visible;
   logic        vsync;
   logic        pause;
   logic [11:0] image_data;
   logic [7:0]  frame_cnt;

   modport master (
      output h_cnt, v_cnt, visible, vsync, pause,
      input  image_data, frame_cnt
   );

   modport slave (
      input  h_cnt, v_cnt, visible, vsync, pause,
      output image_data, frame_cnt
   );
endinterface

// File: rtl/snowman_sprite_gen.sv
// rtl/snowman_sprite_gen.sv - three-ball snowman pixel source for the VGA path
//
// Purpose: renders a snowman on a sky/snow background on a 320x240 grid
//          (2x2 screen pixels per grid pixel) through a 3-stage pipeline, and
//          counts frames on the vsync falling edge.
// Ports:
//   clk   25 MHz pixel clock
//   rst   asynchronous active-low reset
//   bus   snowman_sprite_gen_if.slave (h_cnt, v_cnt, visible, vsync, pause in;
//         image_data, frame_cnt out)
// Optional feature: define SNOWMAN_BOUNCE_EN to compile in the bounce
//   animation FSM; otherwise the anchor is fixed at (160,150) and pause is
//   ignored.

module snowman_sprite_gen #(
   parameter int          STEP_X       = 2,
   parameter int          STEP_Y       = 1,
   parameter logic [11:0] BG_COLOR     = 12'h237,
   parameter logic [11:0] GROUND_COLOR = 12'hDDF,
   parameter logic [11:0] SNOW_COLOR   = 12'hFFF,
   parameter logic [11:0] NOSE_COLOR   = 12'hF80
) (
   input  logic                 clk,
   input  logic                 rst,
   snowman_sprite_gen_if.slave  bus
);

   // Squared distance of a signed offset pair. |a|,|b| < 320 keeps each square
   // below 2^17 and the sum below 2^18, so 18-bit arithmetic is exact.
   function automatic logic [17:0] dist2(input logic signed [10:0] a,
                                         input logic signed [10:0] b);
      logic signed [17:0] ax;
      logic signed [17:0] bx;
      ax = {{7{a[10]}}, a};
      bx = {{7{b[10]}}, b};
      return ax * ax + bx * bx;
   endfunction

   logic [8:0] px;
   logic [8:0] py;

   // ---------------- frame tick ----------------
   logic       vsync_d;
   logic       tick;
   logic [7:0] frame_cnt_r;

   assign tick = vsync_d & ~bus.vsync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vsync_d     <= 1'b1;
         frame_cnt_r <= 8'd0;
      end else begin
         vsync_d <= bus.vsync;
         if (tick) frame_cnt_r <= frame_cnt_r + 8'd1;
      end
   end

   assign bus.frame_cnt = frame_cnt_r;

`ifdef SNOWMAN_BOUNCE_EN
   // ---------------- animation FSM ----------------
   typedef enum logic [1:0] {ST_WAIT, ST_MOVE_X, ST_MOVE_Y} state_t;

   localparam logic signed [10:0] SX = 11'(STEP_X);
   localparam logic signed [10:0] SY = 11'(STEP_Y);

   state_t            state, state_n;
   logic              dir_x, dir_x_n;   // 0 = right, 1 = left
   logic              dir_y, dir_y_n;   // 0 = down,  1 = up
   logic [8:0]        px_n, py_n;
   logic signed [10:0] nx, ny;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_WAIT;
         px    <= 9'd160;
         py    <= 9'd150;
         dir_x <= 1'b0;
         dir_y <= 1'b0;
      end else begin
         state <= state_n;
         px    <= px_n;
         py    <= py_n;
         dir_x <= dir_x_n;
         dir_y <= dir_y_n;
      end
   end

   always_comb begin
      state_n = state;
      px_n    = px;
      py_n    = py;
      dir_x_n = dir_x;
      dir_y_n = dir_y;
      // Widened signed candidates so a step below zero stays negative.
      nx = dir_x ? $signed({2'b00, px}) - SX : $signed({2'b00, px}) + SX;
      ny = dir_y ? $signed({2'b00, py}) - SY : $signed({2'b00, py}) + SY;
      case (state)
         ST_WAIT: begin
            if (tick && !bus.pause) state_n = ST_MOVE_X;
         end
         ST_MOVE_X: begin
            if (nx > 11'sd295) begin
               px_n    = 9'd295;
               dir_x_n = 1'b1;
            end else if (nx < 11'sd24) begin
               px_n    = 9'd24;
               dir_x_n = 1'b0;
            end else begin
               px_n = nx[8:0];
            end
            state_n = ST_MOVE_Y;
         end
         ST_MOVE_Y: begin
            if (ny > 11'sd195) begin
               py_n    = 9'd195;
               dir_y_n = 1'b1;
            end else if (ny < 11'sd72) begin
               py_n    = 9'd72;
               dir_y_n = 1'b0;
            end else begin
               py_n = ny[8:0];
            end
            state_n = ST_WAIT;
         end
         default: state_n = ST_WAIT;
      endcase
   end

   logic unused_bits;
   assign unused_bits = ^{bus.h_cnt[0], bus.v_cnt[0]};
`else
   assign px = 9'd160;
   assign py = 9'd150;

   logic unused_bits;
   assign unused_bits = ^{bus.h_cnt[0], bus.v_cnt[0], bus.pause};
`endif

   // ---------------- S1: grid coordinates ----------------
   logic [8:0] s1_x;
   logic [8:0] s1_y;
   logic       s1_vis;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_x   <= 9'd0;
         s1_y   <= 9'd0;
         s1_vis <= 1'b0;
      end else begin
         s1_x   <= bus.h_cnt[9:1];
         s1_y   <= bus.v_cnt[9:1];
         s1_vis <= bus.visible;
      end
   end

   // ---------------- S2: distances and flags ----------------
   logic signed [10:0] dx, dy_bot, dy_mid, dy_head;
   logic [17:0]        s2_d_bot, s2_d_mid, s2_d_head;
   logic               s2_nose, s2_ground, s2_vis;

   // All three balls share px, so one dx serves them all; the ball centres
   // sit 38 and 62 rows above the anchor.
   assign dx      = $signed({2'b00, s1_x}) - $signed({2'b00, px});
   assign dy_bot  = $signed({2'b00, s1_y}) - $signed({2'b00, py});
   assign dy_mid  = dy_bot + 11'sd38;
   assign dy_head = dy_bot + 11'sd62;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_d_bot  <= 18'd0;
         s2_d_mid  <= 18'd0;
         s2_d_head <= 18'd0;
         s2_nose   <= 1'b0;
         s2_ground <= 1'b0;
         s2_vis    <= 1'b0;
      end else begin
         s2_d_bot  <= dist2(dx, dy_bot);
         s2_d_mid  <= dist2(dx, dy_mid);
         s2_d_head <= dist2(dx, dy_head);
         s2_nose   <= (dy_head == 11'sd0) && (dx >= 11'sd1) && (dx <= 11'sd6);
         s2_ground <= (s1_y >= 9'd220);
         s2_vis    <= s1_vis;
      end
   end

   // ---------------- S3: compare and colour mux ----------------
   logic        ball_hit;
   logic [11:0] pix;
   logic [11:0] image_data_r;

   assign ball_hit = (s2_d_bot  <= 18'd576) ||
                     (s2_d_mid  <= 18'd256) ||
                     (s2_d_head <= 18'd100);

   always_comb begin
      pix = BG_COLOR;
      if (!s2_vis)        pix = 12'h000;
      else if (s2_nose)   pix = NOSE_COLOR;
      else if (ball_hit)  pix = SNOW_COLOR;
      else if (s2_ground) pix = GROUND_COLOR;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) image_data_r <= 12'h000;
      else      image_data_r <= pix;
   end

   assign bus.image_data = image_data_r;

endmodule

// File: doc/snowman_sprite_gen.md
# snowman_sprite_gen

Pixel source for the VGA path: turns the raster counters into a 12-bit RGB444 `image_data` word showing a three-ball snowman on a sky/snow background at 320x240 (each source pixel is 2x2 on screen). Sits directly upstream of `image_display`, in place of the test-pattern generator. Once per frame it moves the snowman with a bounce-off-the-edges animation.

## Interface
Parameters:
- `STEP_X`, 2: horizontal move per frame, in 320-grid pixels.
- `STEP_Y`, 1: vertical move per frame.
- `BG_COLOR`, 12'h237: sky colour.
- `GROUND_COLOR`, 12'hDDF: snow ground colour.
- `SNOW_COLOR`, 12'hFFF: snowman body colour.
- `NOSE_COLOR`, 12'hF80: carrot nose colour.

Ports:
- `clk` in 1: 25 MHz pixel clock; the only clock.
- `rst` in 1: reset, asynchronous, active-low (0 = reset).
- `h_cnt` in 10: horizontal raster counter, 0..799.
- `v_cnt` in 10: vertical raster counter, 0..524.
- `visible` in 1: active-video flag aligned with `h_cnt`/`v_cnt`.
- `vsync` in 1: active-low vertical sync from `vga_controller`.
- `pause` in 1: freezes the animation while high.
- `image_data` out 12: RGB444 as {r,g,b}, registered.
- `frame_cnt` out 8: count of frames since reset, wraps 255->0.

## Operation
- Grid coordinates: x = h_cnt>>1 (0..319), y = v_cnt>>1 (0..239).
- Snowman anchor (px, py) is the centre of the bottom ball.
  - Bottom ball: radius 24, centre (px, py).
  - Middle ball: radius 16, centre (px, py-38).
  - Head: radius 10, centre (px, py-62).
  - Nose: y == py-62 and x in [px+1, px+6].
- Ball hit test: dx²+dy² <= R², where dx and dy are signed 11-bit and the sum is unsigned 18-bit. The test must never truncate.
- Colour priority, highest first:
  1. not visible: 12'h000.
  2. nose: NOSE_COLOR.
  3. any ball: SNOW_COLOR.
  4. y >= 220: GROUND_COLOR.
  5. otherwise: BG_COLOR.
- 3-stage pipeline:
  - S1 registers x, y and visible.
  - S2 registers the per-ball squared distances and the nose/ground flags.
  - S3 registers the compares and the mux into `image_data`.
- Frame tick: vsync is registered into vsync_d. The tick is vsync_d==1 && vsync==0, i.e. the falling edge, one pulse per frame. `frame_cnt` increments on each tick.
- Animation FSM (present only with SNOWMAN_BOUNCE_EN):
  - WAIT: on tick, go to MOVE_X if pause==0; otherwise stay in WAIT.
  - MOVE_X: nx = px ± STEP_X according to dir_x.
    - If nx > 295, set px=295 and dir_x=left.
    - If nx < 24, set px=24 and dir_x=right.
    - Otherwise px=nx.
    - Go to MOVE_Y.
  - MOVE_Y: same rule on py with bounds [72, 195] and dir_y. Go to WAIT.
  - Bounds keep the whole snowman on screen and above the ground line.
  - Underflow must be computed in signed or widened arithmetic, never with a wrapped unsigned value.
- A tick arriving while in MOVE_X or MOVE_Y is ignored. This cannot happen at legal VGA timing.
- px/py change only during vertical blanking, so there is no tearing.

## Timing
- Reset values:
  - image_data=12'h000, frame_cnt=0.
  - px=160, py=150, dir_x=right, dir_y=down.
  - FSM in WAIT, vsync_d=1, pipeline valid flags 0.
- Reset is asynchronous in both directions of effect. Assertion mid-frame clears everything immediately. After release the outputs follow the pipeline within 3 cycles.
- Latency: `image_data` reflects the h_cnt/v_cnt/visible presented 3 clk earlier. The instantiating top must delay hsync/vsync/visible to `image_display` by 3 clk.
- Throughput: one pixel per clock with no stalls.
- Timing of the position update relative to the vsync falling edge:
  - px updates 2 clk after the edge (tick at +1, MOVE_X at +2).
  - py updates at +3.
- pause is sampled only in WAIT on the tick cycle.

## Configuration
- `SNOWMAN_BOUNCE_EN` defined: the FSM, direction flags and movement are compiled in, as described above.
- Not defined: the FSM is compiled out and the anchor is constant at (160,150). `pause` is ignored. `frame_cnt` and rendering are unchanged.

## Test plan
- Reset: hold rst=0 with random inputs. Expect image_data=000, frame_cnt=0. Release, then drive h_cnt=320, v_cnt=300, visible=1; 3 clk later image_data=FFF (anchor centre).
- Colour map, static: (h,v)=(10,10) gives 237; (10,460) gives DDF; (330,176) gives F80 (nose). Any point with visible=0 gives 000. Each result appears exactly 3 clk after its input.
- Right bounce: drive frame ticks from reset. After 68 ticks px=295 and dir_x flips; the next tick gives px=293.
- Pause: hold pause=1 across 5 ticks. px/py stay unchanged and frame_cnt advances by 5.
- frame_cnt wrap: 256 ticks returns frame_cnt to 0.
- Macro off: repeat the bounce scenario. px stays 160 and the pixel at (320,300) stays FFF.
